fetch_stage: RTL and testbench

//  Instruction-fetch front end for the multi-stage RV32I core; sits directly upstream of decode.

---
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, 1-cycle imem read, small fetch buffer toward decode.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module fetch_stage #(
  parameter int              AW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_pc,
  output logic [31:0]   out_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_stall
`endif
);

  // state | meaning
  // RUN   | normal fetch; responses from the current epoch enter the buffer
  // FLUSH | cycle after a redirect; any returning response is stale and dropped

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state;
  logic [AW-1:0]   pc;
  logic [AW-1:0]   resp_pc;
  logic            inflight;
  logic            epoch;
  logic            resp_epoch;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [AW+31:0]  mem [DEPTH];

  logic            pop;
  logic            push;
  logic [CW:0]     occ;
  logic            head_load;
  logic [AW+31:0]  head_next;

  assign out_valid = (count != '0) & ~redirect_valid;
  assign pop       = out_valid & out_ready;
  assign push      = inflight & ~redirect_valid & (resp_epoch == epoch) & (state == RUN);

  // The entry decode takes this cycle counts as free space, so DEPTH=2 still streams 1/cycle.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign imem_req  = rst & ~redirect_valid & (occ < DEPTH_OCC);
  assign imem_addr = pc;

  always_comb begin
    head_load = 1'b0;
    head_next = mem[rd_ptr];
    if (!redirect_valid) begin
      if (pop) head_next = mem[rd_ptr + PW'(1)];
      if (count == '0 || (count == CW'(1) && pop)) begin
        head_next = {resp_pc, imem_rdata};
        head_load = push;
      end else begin
        head_load = pop;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {resp_pc, imem_rdata};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      resp_pc    <= '0;
      inflight   <= 1'b0;
      epoch      <= 1'b0;
      resp_epoch <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      out_pc     <= '0;
      out_instr  <= 32'h0000_0013;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc         <= pc + AW'(4);
        resp_pc    <= pc;
        resp_epoch <= epoch;
      end
      if (redirect_valid) begin
        state  <= FLUSH;
        pc     <= {redirect_pc[AW-1:2], 2'b00};
        epoch  <= ~epoch;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        state <= RUN;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
      if (head_load) {out_pc, out_instr} <= head_next;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (out_valid && !out_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random redirect/stall/reset traffic,
// checked cycle by cycle against a queue-based model of the fetch buffer.
module tb_fetch_stage;
  localparam int DEPTH = 2;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_pc;
  logic [31:0]   out_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_stall;
  int unsigned   m_fetched;
  int unsigned   m_stall;
`endif

  fetch_stage #(.AW(AW), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc, m_infl_pc, m_last_pc, m_last_instr;
  bit          m_infl;
  logic [31:0] data_xor = '0;
  logic [31:0] acc[$];

  task automatic model_reset();
    q.delete();
    m_infl       = 0;
    m_pc         = 32'h0;
    m_last_pc    = 32'h0;
    m_last_instr = 32'h0000_0013;
`ifdef FETCH_PERF_CNT_EN
    m_fetched = 0;
    m_stall   = 0;
`endif
  endtask

  task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    bit          e_valid, e_pop, e_req;
    int          occ;
    logic [31:0] e_pc, e_instr, laddr;
    logic        lreq;
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    if (!r) model_reset();
    #1;
    e_valid = r && (q.size() != 0) && !rv;
    e_pop   = e_valid && rdy;
    occ     = q.size() + int'(m_infl) - int'(e_pop);
    e_req   = r && !rv && (occ < DEPTH);
    e_pc    = (q.size() != 0) ? q[0].pc    : m_last_pc;
    e_instr = (q.size() != 0) ? q[0].instr : m_last_instr;
    check("imem_req", imem_req, e_req);
    if (e_req) check("imem_addr", imem_addr, m_pc);
    check("out_valid", out_valid, e_valid);
    check("out_pc", out_pc, e_pc);
    check("out_instr", out_instr, e_instr);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_stall", perf_stall, m_stall);
`endif
    if (out_valid && rdy) acc.push_back(out_pc);
    lreq  = imem_req;
    laddr = imem_addr;
    @(posedge clk);
    if (r) begin
`ifdef FETCH_PERF_CNT_EN
      if (e_pop) m_fetched++;
      if (e_valid && !rdy) m_stall++;
`endif
      if (rv) begin
        q.delete();
        m_infl = 0;
        m_pc   = {rpc[31:2], 2'b00};
      end else begin
        if (e_pop) void'(q.pop_front());
        if (m_infl) q.push_back('{m_infl_pc, m_infl_pc ^ data_xor});
        m_infl = e_req;
        if (e_req) begin
          m_infl_pc = m_pc;
          m_pc      = m_pc + 32'd4;
        end
      end
      if (q.size() > DEPTH) check("buffer_overflow", 64'(q.size()), 64'(DEPTH));
      if (q.size() != 0) begin
        m_last_pc    = q[0].pc;
        m_last_instr = q[0].instr;
      end
    end
    #1 imem_rdata = lreq ? (laddr ^ data_xor) : 32'h0;
  endtask

  task automatic run_ready(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    model_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // 1: streaming from reset, one instruction per cycle starting in cycle 2
    acc.delete();
    run_ready(8);
    check("t1_count", 64'(acc.size()), 64'd6);
    for (int i = 0; i < 6 && i < acc.size(); i++) check("t1_pc", acc[i], 32'(4 * i));

    // 2: decode stalled, buffer fills to DEPTH, then drains without gap or duplicate
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("t2_req_stalled", imem_req, 1'b0);
    check("t2_pc_stable", out_pc, 32'h0);
    acc.delete();
    run_ready(4);
    check("t2_count", 64'(acc.size()), 64'd4);
    for (int i = 0; i < 4 && i < acc.size(); i++) check("t2_pc", acc[i], 32'(4 * i));

    // 3: redirect while the response for 0x8 is in flight
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    acc.delete();
    run_ready(3);
    cycle(1'b1, 1'b1, 32'h0000_0100, 1'b1);
    run_ready(5);
    check("t3_first", acc.size() > 0 ? acc[0] : 32'hFFFF_FFFF, 32'h0);
    check("t3_target", acc.size() > 1 ? acc[1] : 32'hFFFF_FFFF, 32'h0000_0100);
    foreach (acc[i]) if (acc[i] == 32'h8) check("t3_squashed_0x8", acc[i], 32'hFFFF_FFFF);

    // 4: redirect in the same cycle decode would have accepted
    acc.delete();
    cycle(1'b1, 1'b1, 32'h0000_0203, 1'b1);
    check("t4_no_accept", 64'(acc.size()), 64'd0);
    run_ready(4);
    check("t4_target", acc.size() > 0 ? acc[0] : 32'hFFFF_FFFF, 32'h0000_0200);

    // 5: PC wraps past the top of the address space
    acc.delete();
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    run_ready(5);
    check("t5_top", acc.size() > 0 ? acc[0] : 32'h1, 32'hFFFF_FFFC);
    check("t5_wrap", acc.size() > 1 ? acc[1] : 32'h1, 32'h0000_0000);
    check("t5_next", acc.size() > 2 ? acc[2] : 32'h1, 32'h0000_0004);

    // 6: reset pulsed mid-stream, then restart from RESET_PC
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("t6_out_pc", out_pc, 32'h0);
    check("t6_out_instr", out_instr, 32'h0000_0013);
    acc.delete();
    run_ready(3);
    check("t6_restart", acc.size() > 0 ? acc[0] : 32'hFFFF_FFFF, 32'h0);

    // random traffic with a scrambled memory image
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    data_xor = $urandom;
    for (int i = 0; i < 3000; i++) begin
      logic r, rv, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 149) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : $urandom;
      cycle(r, rv, rpc, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
